// File: rtl/cache_line_fill_ctrl.sv
// Direct-mapped read cache controller: tag/valid lookup, 32-beat req/ack line refill,
// one-cycle response pulse and saturating hit/miss statistics.
module cache_line_fill_ctrl #(
    parameter int TAG_W   = 4,
    parameter int INDEX_W = 2,
    parameter int OFF_W   = 5,
    parameter int DATA_W  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cpu_req,
    input  logic [TAG_W+INDEX_W+OFF_W-1:0] cpu_addr,
    output logic [DATA_W-1:0]              cpu_rdata,
    output logic                           cpu_ready,
    input  logic                           flush,
    output logic                           mem_req,
    output logic [TAG_W+INDEX_W+OFF_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]              mem_rdata,
    input  logic                           mem_ack,
    output logic [7:0]                     hit_cnt,
    output logic [7:0]                     miss_cnt
);
    localparam int AW         = TAG_W + INDEX_W + OFF_W;
    localparam int NUM_LINES  = 2 ** INDEX_W;
    localparam int LINE_BYTES = 2 ** OFF_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        addr_q;
    logic [TAG_W-1:0]     addr_tag;
    logic [INDEX_W-1:0]   addr_idx;
    logic [OFF_W-1:0]     addr_off;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [DATA_W-1:0]    data_mem [NUM_LINES][LINE_BYTES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] line_sel;
    logic [OFF_W-1:0]     beat;
    logic [OFF_W-1:0]     beat_inc;
    logic                 refilled;
    logic                 hit;
    logic                 latch_go, hit_go, miss_go, beat_ack, last_beat;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign addr_tag = addr_q[AW-1 -: TAG_W];
    assign addr_idx = addr_q[OFF_W +: INDEX_W];
    assign addr_off = addr_q[OFF_W-1:0];
    assign line_sel = NUM_LINES'(1) << addr_idx;
    assign beat_inc = beat + OFF_W'(1);
    assign hit      = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_go  = 1'b0;
        hit_go    = 1'b0;
        miss_go   = 1'b0;
        beat_ack  = 1'b0;
        last_beat = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    latch_go  = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    hit_go    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    miss_go   = 1'b1;
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    beat_ack = 1'b1;
                    if (beat == '1) begin
                        last_beat = 1'b1;
                        state_nxt = LOOKUP;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and registered outputs; refilled suppresses statistics on the re-lookup after a fill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            beat      <= '0;
            refilled  <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            cpu_ready <= hit_go;
            if (latch_go) refilled <= 1'b0;
            if (hit_go) begin
                cpu_rdata <= data_mem[addr_idx][addr_off];
                if (!refilled) hit_cnt <= sat_inc(hit_cnt);
            end
            if (miss_go) begin
                beat     <= '0;
                mem_req  <= 1'b1;
                mem_addr <= {addr_tag, addr_idx, {OFF_W{1'b0}}};
                if (!refilled) miss_cnt <= sat_inc(miss_cnt);
            end
            if (beat_ack && !last_beat) begin
                beat     <= beat_inc;
                mem_addr <= {addr_tag, addr_idx, beat_inc};
            end
            if (last_beat) begin
                mem_req  <= 1'b0;
                refilled <= 1'b1;
            end
            // A flush landing on the final beat still leaves the freshly filled line valid
            if (flush) begin
                valid <= last_beat ? line_sel : '0;
            end else if (miss_go) begin
                valid <= valid & ~line_sel;
            end else if (last_beat) begin
                valid <= valid | line_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latch_go)  addr_q <= cpu_addr;
        if (last_beat) tag_mem[addr_idx] <= addr_tag;
        if (beat_ack)  data_mem[addr_idx][beat] <= mem_rdata;
    end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Randomized bench for cache_line_fill_ctrl against a line-level cache model and a
// bench-driven memory responder with variable ack delay.
module tb_cache_line_fill_ctrl;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset, cpu_req, flush, mem_ack;
    logic [AW-1:0] cpu_addr, mem_addr;
    logic [7:0]    cpu_rdata, mem_rdata, hit_cnt, miss_cnt;
    logic          cpu_ready, mem_req;

    cache_line_fill_ctrl dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: per-line valid/tag/bytes plus unbounded event counts
    bit         mv [4];
    logic [3:0] mt [4];
    logic [7:0] md [4][32];
    int         m_hit, m_miss;
    logic [7:0] last_rdata;
    bit         rand_data;
    int         max_wait;

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        m_hit = 0;
        m_miss = 0;
        last_rdata = 8'h00;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    endtask

    // One CPU read; the bench also plays memory. flush_beat/rst_beat < 0 disables those events.
    task automatic do_read(input logic [AW-1:0] a, input int flush_beat, input int rst_beat);
        logic [3:0]    t;
        logic [1:0]    idx;
        logic [4:0]    off;
        logic [4:0]    b5;
        logic [AW-1:0] ba;
        logic [7:0]    served [32];
        logic [7:0]    exp_data;
        bit            exp_hit, done, aborted;
        int            cyc, beat, wt, req_cycles, ready_cyc;
        t   = a[10:7];
        idx = a[6:5];
        off = a[4:0];
        chk("rdata_hold", 32'(cpu_rdata), 32'(last_rdata));
        exp_hit = mv[idx] && (mt[idx] == t);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        cyc = 0; beat = 0; req_cycles = 0; ready_cyc = 0;
        done = 1'b0; aborted = 1'b0;
        wt = $urandom_range(max_wait, 0);
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            cpu_req = 1'b0;
            mem_ack = 1'b0;
            flush   = 1'b0;
            if (cpu_ready) begin
                done = 1'b1;
                ready_cyc = cyc;
            end else if (mem_req) begin
                if (req_cycles == 0) chk("req_rise", 32'(cyc), 32'd2);
                req_cycles++;
                if (beat > 31) begin
                    chk("req_drop", 32'(mem_req), 32'd0);
                end else begin
                    b5 = beat[4:0];
                    ba = {t, idx, b5};
                    chk("mem_addr", 32'(mem_addr), 32'(ba));
                    if (beat == rst_beat) begin
                        reset = 1'b1;
                        #1;
                        chk("rst_req", 32'(mem_req), 32'd0);
                        aborted = 1'b1;
                        done = 1'b1;
                    end else if (wt == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rand_data ? 8'($urandom) : ba[7:0];
                        served[beat] = mem_rdata;
                        if (beat == flush_beat) flush = 1'b1;
                        beat++;
                        wt = $urandom_range(max_wait, 0);
                    end else begin
                        wt--;
                        cpu_req  = 1'($urandom_range(1, 0));
                        cpu_addr = 11'($urandom);
                    end
                end
            end else begin
                mem_ack   = 1'($urandom_range(1, 0));
                mem_rdata = 8'($urandom);
            end
        end
        mem_ack = 1'b0;
        cpu_req = 1'b0;
        flush   = 1'b0;
        if (aborted) begin
            @(negedge clk);
            reset = 1'b0;
            model_reset();
            chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
            chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
            chk("rst_ready", 32'(cpu_ready), 32'd0);
            return;
        end
        chk("ready_seen", 32'(done), 32'd1);
        if (exp_hit) begin
            chk("hit_lat", 32'(ready_cyc), 32'd2);
            chk("hit_noreq", 32'(req_cycles), 32'd0);
            exp_data = md[idx][off];
            m_hit++;
        end else begin
            chk("beats", 32'(beat), 32'd32);
            chk("miss_lat", 32'(ready_cyc), 32'(req_cycles + 3));
            if (max_wait == 0) chk("miss_lat0", 32'(ready_cyc), 32'd35);
            m_miss++;
            if (flush_beat >= 0) for (int i = 0; i < 4; i++) mv[i] = 1'b0;
            mv[idx] = 1'b1;
            mt[idx] = t;
            for (int i = 0; i < 32; i++) md[idx][i] = served[i];
            exp_data = served[off];
        end
        chk("rdata", 32'(cpu_rdata), 32'(exp_data));
        last_rdata = exp_data;
        chk("hit_cnt", 32'(hit_cnt), 32'(sat255(m_hit)));
        chk("miss_cnt", 32'(miss_cnt), 32'(sat255(m_miss)));
        @(negedge clk);
        chk("ready_pulse", 32'(cpu_ready), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            fb, r;
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        reset = 1'b0;

        // Directed: cold miss, hit, conflict misses, flush cases
        max_wait = 0;
        rand_data = 1'b0;
        do_read(11'h123, -1, -1);
        do_read(11'h13F, -1, -1);
        do_read(11'h523, -1, -1);
        do_read(11'h123, -1, -1);
        pulse_flush();
        do_read(11'h123, -1, -1);
        do_read(11'h040, -1, -1);
        do_read(11'h2A4, 31, -1);
        do_read(11'h2A4, -1, -1);
        do_read(11'h040, -1, -1);
        do_read(11'h7C0, 12, -1);
        do_read(11'h7DD, -1, -1);

        // Backpressure, then reset in the middle of a refill
        max_wait = 5;
        rand_data = 1'b1;
        do_read(11'h3C7, -1, -1);
        do_read(11'h3D0, -1, -1);
        do_read(11'h6E1, -1, 10);
        do_read(11'h6E1, -1, -1);

        // Random traffic over a small tag pool so hits and conflicts both occur
        for (int n = 0; n < 40; n++) begin
            max_wait = $urandom_range(3, 0);
            ra = {3'b000, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 5'($urandom_range(31, 0))};
            ra[10:8] = 3'($urandom_range(1, 0) * 5);
            r = $urandom_range(7, 0);
            fb = (r == 0) ? 31 : (r == 1) ? $urandom_range(30, 0) : -1;
            if ($urandom_range(9, 0) == 0) pulse_flush();
            do_read(ra, fb, -1);
        end

        // Hit counter saturation
        max_wait = 0;
        do_read(11'h155, -1, -1);
        for (int n = 0; n < 300; n++) do_read({6'b001010, 5'($urandom_range(31, 0))}, -1, -1);
        chk("hit_sat", 32'(hit_cnt), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule
